// File: rtl/f1_pkg.sv
// Shared types and constants for the F1 start-light sequencer.
// The state encoding and the default LFSR feedback mask live here.
package f1_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    HOLD
  } f1_state_t;

  // Galois mask for x^7 + x^6 + 1, maximal length at width 7
  localparam logic [6:0] F1_LFSR_TAPS_7 = 7'h60;

endpackage

// File: rtl/f1_light_seq_lfsr.sv
// Free-running right-shift Galois LFSR used as the random hold-length source.
// It never reaches zero from a nonzero seed.
module lfsr_galois #(
  parameter int               WIDTH = 7,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(7'h60),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= SEED;
    end else if (q[0]) begin
      q <= (q >> 1) ^ TAPS;
    end else begin
      q <= q >> 1;
    end
  end

endmodule

// File: rtl/f1_light_seq.sv
// Start-light sequencer: fills the lamps one per tick, holds them for a fixed
// or LFSR-derived number of ticks, then blanks them and pulses go.
module f1_light_seq
  import f1_pkg::*;
#(
  parameter int                 N_LIGHTS  = 8,
  parameter int                 DELAY_W   = 7,
  parameter logic [DELAY_W-1:0] LFSR_TAPS = DELAY_W'(F1_LFSR_TAPS_7),
  parameter logic [DELAY_W-1:0] SEED      = DELAY_W'(1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                trigger,
  input  logic                tick,
  input  logic                abort,
  input  logic                mode_fixed,
  input  logic [DELAY_W-1:0]  hold_fixed,
  output logic [N_LIGHTS-1:0] lights,
  output logic                busy,
  output logic                go
);

  f1_state_t           state_q, state_d;
  logic [N_LIGHTS-1:0] lights_q, lights_d;
  logic [DELAY_W-1:0]  count_q, count_d;
  logic                go_q, go_d;
  logic [DELAY_W-1:0]  lfsr_q;
  logic [DELAY_W-1:0]  hold_len;
  logic [DELAY_W-1:0]  hold_load;

  lfsr_galois #(
    .WIDTH (DELAY_W),
    .TAPS  (LFSR_TAPS),
    .SEED  (SEED)
  ) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr_q)
  );

  // A zero length would never expire, so it is promoted to a single tick.
  always_comb begin
    hold_len  = mode_fixed ? hold_fixed : lfsr_q;
    hold_load = (hold_len == '0) ? DELAY_W'(1) : hold_len;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      lights_q <= '0;
      count_q  <= '0;
      go_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      lights_q <= lights_d;
      count_q  <= count_d;
      go_q     <= go_d;
    end
  end

  // The lamp pattern is always contiguous ones from bit 0, so bit N-2 being
  // set means this tick completes the fill.
  always_comb begin
    state_d  = state_q;
    lights_d = lights_q;
    count_d  = count_q;
    go_d     = 1'b0;

    if (abort) begin
      state_d  = IDLE;
      lights_d = '0;
      count_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          lights_d = '0;
          if (trigger) begin
            state_d = FILL;
          end
        end
        FILL: begin
          if (tick) begin
            lights_d = {lights_q[N_LIGHTS-2:0], 1'b1};
            if (lights_q[N_LIGHTS-2]) begin
              state_d = HOLD;
              count_d = hold_load;
            end
          end
        end
        HOLD: begin
          if (tick) begin
            if (count_q <= DELAY_W'(1)) begin
              state_d  = IDLE;
              lights_d = '0;
              count_d  = '0;
              go_d     = 1'b1;
            end else begin
              count_d = count_q - DELAY_W'(1);
            end
          end
        end
        default: begin
          state_d  = IDLE;
          lights_d = '0;
          count_d  = '0;
        end
      endcase
    end
  end

  assign lights = lights_q;
  assign go     = go_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_f1_light_seq.sv
// Scoreboard bench for f1_light_seq: a behavioural model pushes the expected
// outputs for each driven cycle, and each scenario task pops and compares them.
module tb_f1_light_seq;
  import f1_pkg::*;

  localparam int N = 8;
  localparam int W = 7;
  localparam logic [W-1:0] TB_SEED = W'(1);

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         trigger = 1'b0;
  logic         tick = 1'b0;
  logic         abort = 1'b0;
  logic         mode_fixed = 1'b1;
  logic [W-1:0] hold_fixed = W'(3);
  logic [N-1:0] lights;
  logic         busy;
  logic         go;

  typedef struct packed {
    logic [N-1:0] lights;
    logic         busy;
    logic         go;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  f1_state_t    m_st;
  int           m_filled;
  logic [N-1:0] m_lights;
  int           m_cnt;
  logic         m_go;
  logic [W-1:0] m_lfsr;
  int           m_captured;

  f1_light_seq #(
    .N_LIGHTS  (N),
    .DELAY_W   (W),
    .LFSR_TAPS (W'(7'h60)),
    .SEED      (TB_SEED)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .trigger    (trigger),
    .tick       (tick),
    .abort      (abort),
    .mode_fixed (mode_fixed),
    .hold_fixed (hold_fixed),
    .lights     (lights),
    .busy       (busy),
    .go         (go)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] lfsr_next(input logic [W-1:0] v);
    return v[0] ? ((v >> 1) ^ W'(7'h60)) : (v >> 1);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= TB_SEED;
    else     m_lfsr <= lfsr_next(m_lfsr);
  end

  task automatic model_reset();
    m_st = IDLE; m_filled = 0; m_lights = '0; m_cnt = 0; m_go = 1'b0;
  endtask

  // Drive one cycle of inputs, predict the outputs after the edge, push them.
  task automatic drive(input logic trg, input logic tk, input logic ab);
    exp_t e;
    @(negedge clk);
    trigger = trg; tick = tk; abort = ab;
    m_go = 1'b0;
    if (ab) begin
      m_st = IDLE; m_filled = 0; m_lights = '0; m_cnt = 0;
    end else begin
      case (m_st)
        IDLE: if (trg) begin m_st = FILL; m_filled = 0; end
        FILL: if (tk) begin
          m_filled++;
          m_lights = N'((64'd1 << m_filled) - 64'd1);
          if (m_filled == N) begin
            m_captured = mode_fixed ? int'(hold_fixed) : int'(m_lfsr);
            if (m_captured == 0) m_captured = 1;
            m_cnt = m_captured;
            m_st  = HOLD;
          end
        end
        HOLD: if (tk) begin
          m_cnt--;
          if (m_cnt == 0) begin
            m_st = IDLE; m_lights = '0; m_filled = 0; m_go = 1'b1;
          end
        end
        default: ;
      endcase
    end
    e = {m_lights, (m_st != IDLE), m_go};
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    n_tests++;
    if (lights !== '0 || busy !== 1'b0 || go !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: lights=%h busy=%b go=%b, expected 00/0/0", lights, busy, go);
    end
    n_tests++;
    if (dut.u_lfsr.q !== TB_SEED) begin
      n_fail++;
      $display("[TB] FAIL reset_lfsr: got %h, expected %h", dut.u_lfsr.q, TB_SEED);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_basic_fixed();
    exp_t o, e;
    mode_fixed = 1'b1; hold_fixed = W'(3);
    for (int k = 0; k <= 11; k++) begin
      drive(k == 0, 1'b0, 1'b0);
      if (k > 0) begin
        for (int j = 0; j < 3; j++) begin
          o = {lights, busy, go}; e = sb.pop_front(); n_tests++;
          if (o !== e) begin
            n_fail++;
            $display("[TB] FAIL basic_gap k=%0d: got %h/%b/%b, expected %h/%b/%b", k, o.lights, o.busy, o.go, e.lights, e.busy, e.go);
          end
          if (j < 2) drive(1'b0, 1'b0, 1'b0);
        end
      end else begin
        o = {lights, busy, go}; e = sb.pop_front(); n_tests++;
        if (o !== e) begin
          n_fail++;
          $display("[TB] FAIL basic_trigger: got %h/%b/%b, expected %h/%b/%b", o.lights, o.busy, o.go, e.lights, e.busy, e.go);
        end
      end
      if (k < 11) drive(1'b0, 1'b1, 1'b0);
      else        drive(1'b0, 1'b0, 1'b0);
      o = {lights, busy, go}; e = sb.pop_front(); n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("[TB] FAIL basic_tick k=%0d: got %h/%b/%b, expected %h/%b/%b", k + 1, o.lights, o.busy, o.go, e.lights, e.busy, e.go);
      end
      if (k + 1 <= 8) begin
        n_tests++;
        if (lights !== N'((64'd1 << (k + 1)) - 64'd1)) begin
          n_fail++;
          $display("[TB] FAIL basic_fill k=%0d: lights=%h", k + 1, lights);
        end
      end
      if (k == 10) begin
        n_tests++;
        if (go !== 1'b1 || lights !== '0 || busy !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL basic_go: lights=%h busy=%b go=%b, expected 00/0/1", lights, busy, go);
        end
      end
    end
  endtask

  task automatic test_zero_hold();
    exp_t o, e;
    int go_count = 0;
    mode_fixed = 1'b1; hold_fixed = '0;
    for (int i = 0; i < 13; i++) begin
      drive(i == 0, 1'b1, 1'b0);
      go_count += int'(go);
      o = {lights, busy, go}; e = sb.pop_front(); n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("[TB] FAIL zero_hold step=%0d: got %h/%b/%b, expected %h/%b/%b", i, o.lights, o.busy, o.go, e.lights, e.busy, e.go);
      end
    end
    n_tests++;
    if (go_count !== 1) begin
      n_fail++;
      $display("[TB] FAIL zero_hold_go_width: go high %0d cycles, expected 1", go_count);
    end
  endtask

  task automatic test_abort();
    exp_t o, e;
    mode_fixed = 1'b1; hold_fixed = W'(3);
    for (int i = 0; i < 15; i++) begin
      if (i == 0)       drive(1'b1, 1'b0, 1'b0);
      else if (i <= 9)  drive(1'b0, 1'b1, 1'b0);
      else if (i == 10) drive(1'b1, 1'b1, 1'b1);
      else if (i <= 12) drive(1'b0, 1'b1, 1'b0);
      else if (i == 13) drive(1'b1, 1'b0, 1'b0);
      else              drive(1'b0, 1'b1, 1'b0);
      o = {lights, busy, go}; e = sb.pop_front(); n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("[TB] FAIL abort step=%0d: got %h/%b/%b, expected %h/%b/%b", i, o.lights, o.busy, o.go, e.lights, e.busy, e.go);
      end
      if (i == 10) begin
        n_tests++;
        if (lights !== '0 || busy !== 1'b0 || go !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL abort_hold: lights=%h busy=%b go=%b, expected 00/0/0", lights, busy, go);
        end
      end
      if (i == 14) begin
        n_tests++;
        if (lights !== N'(1)) begin
          n_fail++;
          $display("[TB] FAIL abort_restart: lights=%h, expected 01", lights);
        end
      end
    end
    drive(1'b0, 1'b0, 1'b1);
    void'(sb.pop_front());
  endtask

  task automatic test_trigger_ignored();
    exp_t o, e;
    bit done = 0;
    mode_fixed = 1'b1; hold_fixed = W'(2);
    for (int i = 0; i < 40 && !done; i++) begin
      if (i == 0)      drive(1'b1, 1'b1, 1'b0);
      else if (i <= 3) drive(1'b0, 1'b1, 1'b0);
      else if (i == 4) drive(1'b1, 1'b0, 1'b0);
      else             drive(1'b0, 1'b1, 1'b0);
      o = {lights, busy, go}; e = sb.pop_front(); n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("[TB] FAIL trig_ign step=%0d: got %h/%b/%b, expected %h/%b/%b", i, o.lights, o.busy, o.go, e.lights, e.busy, e.go);
      end
      if (i == 0 || i == 4) begin
        n_tests++;
        if (lights !== (i == 0 ? N'(0) : N'(8'h07)) || busy !== 1'b1) begin
          n_fail++;
          $display("[TB] FAIL trig_ign_lamps step=%0d: lights=%h busy=%b", i, lights, busy);
        end
      end
      if (i > 4 && go === 1'b1) done = 1;
    end
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("[TB] FAIL trig_ign_timeout: go never seen, busy=%b", busy);
    end
  endtask

  task automatic test_back_to_back();
    exp_t o, e;
    mode_fixed = 1'b1; hold_fixed = W'(1);
    for (int i = 0; i < 12; i++) begin
      if (i == 0 || i == 10) drive(1'b1, 1'b0, 1'b0);
      else                   drive(1'b0, 1'b1, 1'b0);
      o = {lights, busy, go}; e = sb.pop_front(); n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("[TB] FAIL b2b step=%0d: got %h/%b/%b, expected %h/%b/%b", i, o.lights, o.busy, o.go, e.lights, e.busy, e.go);
      end
    end
    n_tests++;
    if (lights !== N'(1) || busy !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL b2b_restart: lights=%h busy=%b, expected 01/1", lights, busy);
    end
    drive(1'b0, 1'b0, 1'b1);
    void'(sb.pop_front());
  endtask

  task automatic test_async_reset();
    exp_t o, e;
    mode_fixed = 1'b1; hold_fixed = W'(3);
    for (int i = 0; i < 6; i++) begin
      drive(i == 0, i != 0, 1'b0);
      o = {lights, busy, go}; e = sb.pop_front(); n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("[TB] FAIL arst_fill step=%0d: got %h/%b/%b, expected %h/%b/%b", i, o.lights, o.busy, o.go, e.lights, e.busy, e.go);
      end
    end
    @(negedge clk);
    tick = 1'b0;
    #1 rst = 1'b1;
    #1;
    n_tests++;
    if (lights !== '0 || busy !== 1'b0 || go !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL arst_outputs: lights=%h busy=%b go=%b, expected 00/0/0", lights, busy, go);
    end
    n_tests++;
    if (dut.u_lfsr.q !== TB_SEED) begin
      n_fail++;
      $display("[TB] FAIL arst_lfsr: got %h, expected %h", dut.u_lfsr.q, TB_SEED);
    end
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic test_random_hold();
    exp_t o, e;
    int ticks;
    bit seen;
    mode_fixed = 1'b0; hold_fixed = W'(5);
    for (int r = 0; r < 3; r++) begin
      for (int g = 0; g < r * 7 + 2; g++) begin
        drive(1'b0, 1'b0, 1'b0);
        void'(sb.pop_front());
      end
      drive(1'b1, 1'b0, 1'b0);
      void'(sb.pop_front());
      ticks = 0; seen = 0;
      for (int i = 0; i < 200 && !seen; i++) begin
        drive(1'b0, 1'b1, 1'b0);
        ticks++;
        o = {lights, busy, go}; e = sb.pop_front(); n_tests++;
        if (o !== e) begin
          n_fail++;
          $display("[TB] FAIL rand_seq r=%0d tick=%0d: got %h/%b/%b, expected %h/%b/%b", r, ticks, o.lights, o.busy, o.go, e.lights, e.busy, e.go);
        end
        if (go === 1'b1) seen = 1;
      end
      n_tests++;
      if (!seen || ticks - N !== m_captured || ticks - N < 1) begin
        n_fail++;
        $display("[TB] FAIL rand_hold r=%0d: hold ticks=%0d go_seen=%b, expected %0d", r, ticks - N, seen, m_captured);
      end
    end
    mode_fixed = 1'b1;
  endtask

  task automatic test_lfsr_period();
    logic [W-1:0] start;
    int period = 0;
    int bad = 0;
    @(posedge clk); #1;
    start = dut.u_lfsr.q;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk); #1;
      if (dut.u_lfsr.q !== m_lfsr || dut.u_lfsr.q == '0) bad++;
      if (period == 0 && dut.u_lfsr.q === start) period = i;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("[TB] FAIL lfsr_sequence: %0d cycles disagree with model or hit zero, expected 0", bad);
    end
    n_tests++;
    if (period != 127) begin
      n_fail++;
      $display("[TB] FAIL lfsr_period: got %0d, expected 127", period);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic_fixed();
    test_zero_hold();
    test_abort();
    test_trigger_ignored();
    test_back_to_back();
    test_async_reset();
    test_random_hold();
    test_lfsr_period();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/f1_light_seq.md
# f1_light_seq

Parametrised start-light sequencer for the F1 reaction-timer datapath. On a trigger it lights `N_LIGHTS` lamps one at a time, one per `tick`. It then holds all lamps on for a fixed or pseudo-random number of ticks, extinguishes them together and emits a one-cycle `go` pulse for the reaction timer. It sits between the tick divider and the lamp driver/reaction counter.

## Interface
- `N_LIGHTS`, 8: number of lamps, 2..32.
- `DELAY_W`, 7: hold-counter and LFSR width, 4..16.
- `LFSR_TAPS`, 7'h60: Galois feedback mask for the LFSR (x^7+x^6+1 at width 7).
- `SEED`, 1: LFSR reset value, must be nonzero.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `trigger`  in  1  start request, sampled only in IDLE.
- `tick`  in  1  one-cycle step enable from the divider.
- `abort`  in  1  synchronous cancel, highest priority after `rst`.
- `mode_fixed`  in  1  1: hold length = `hold_fixed`; 0: hold length = LFSR.
- `hold_fixed`  in  DELAY_W  fixed hold length in ticks.
- `lights`  out  N_LIGHTS  lamp pattern, registered.
- `busy`  out  1  high whenever state != IDLE.
- `go`  out  1  one-cycle pulse when the lamps go out.

## Operation
- States: IDLE, FILL, HOLD.
- IDLE:
  - `lights` = 0.
  - On `trigger`: go to FILL with `lights` = 0. A `tick` in the same cycle is not counted.
- FILL:
  - Each `tick` does `lights <= {lights[N_LIGHTS-2:0], 1'b1}`.
  - The tick that sets the final bit (all ones) moves to HOLD. In that same cycle the hold counter loads the captured length: `hold_fixed` if `mode_fixed`, else the current LFSR value.
  - A captured length of 0 is replaced by 1.
- HOLD:
  - `lights` stays all ones.
  - Each `tick` decrements the counter.
  - A tick while the counter is 1 clears `lights` to 0, asserts `go` for one cycle and returns to IDLE.
- `abort`, in any state:
  - Next state IDLE, `lights` = 0, `go` = 0, counter cleared.
  - Overrides a coincident `tick` or `trigger`.
- `trigger` outside IDLE is ignored.
- `mode_fixed` and `hold_fixed` are sampled only at the FILL→HOLD transition.
- LFSR:
  - Advances every clk cycle regardless of state, so its value is decorrelated from trigger timing.
  - Never reaches 0.
  - Period is 2^DELAY_W−1 for maximal taps.
- Reset: state IDLE, `lights` = 0, `busy` = 0, `go` = 0, counter = 0, LFSR = `SEED`.

## Timing
- All outputs are registered and change in the cycle after the sampled input event.
- Trigger at cycle t: `busy` = 1 from t+1.
- k-th tick in FILL at cycle t: `lights` has k ones from t+1.
- Total sequence = N_LIGHTS ticks (fill) + H ticks (hold).
- `go` and `lights` = 0 appear together in the cycle after the final HOLD tick. `busy` falls in that same cycle.
- `go` is exactly one clk wide, even if `tick` is held high.
- A new `trigger` is accepted in the cycle `go` is high (state is already IDLE).
- Async `rst` mid-sequence forces the reset values immediately. There is no `go` on reset.

## Structure
- Package `f1_pkg`:
  - `typedef enum logic [1:0] {IDLE, FILL, HOLD} f1_state_t`.
  - Default tap constant `F1_LFSR_TAPS_7`.
- Sub-module `lfsr_galois` (params WIDTH, TAPS, SEED; ports clk, rst, q). It free-runs.
- Top level: the FSM plus the lights shift register and hold counter.

## Test plan
- N=8, `mode_fixed`=1, `hold_fixed`=3: trigger, then ticks every 4 cycles → `lights` 01,03,07,…,FF. After 3 more ticks, `lights`=00 and `go` is high for exactly 1 cycle; `busy` 1→0 in that cycle.
- `hold_fixed`=0 → hold is 1 tick. `tick` held constant high → FILL/HOLD advance every cycle, `go` is still 1 cycle wide.
- `abort` asserted in HOLD with a coincident tick → next cycle `lights`=0, `busy`=0, no `go`. A following trigger restarts from 01.
- `trigger` in FILL (`lights`=07) is ignored. `trigger`+`tick` together in IDLE → `lights` stays 00 for that cycle, the first counted tick gives 01.
- Async `rst` pulsed mid-FILL (`lights`=1F) → `lights`=0 and `busy`=0 without waiting for a clk edge. The LFSR reloads `SEED`=1.
- `mode_fixed`=0, SEED=1, DELAY_W=7: the hold tick count equals the model LFSR value at FILL→HOLD and is never 0. A free-run check confirms the LFSR period is 127.
